param_demux_router: RTL and testbench

- Parametrised successor of the 4-way source-select demux.
- Routes one input stream to NUM_OUT output channels, selected per beat by in_src.
- Each channel has its own FIFO of FIFO_DEPTH entries with valid/ready handshakes on both sides, so a stalled output does not lose data.
- Sits between the packet source and the per-channel consumers.

---
 rtl/demux_router_pkg.sv | 23 ++
 rtl/param_demux_router_if.sv | 30 +++
 rtl/demux_router_fifo.sv | 67 ++++++
 rtl/param_demux_router.sv | 89 ++++++++
 tb/tb_param_demux_router.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_router_pkg.sv
// Shared sizing helpers and constants for the parametrised demux router.
package demux_router_pkg;

    localparam int DROP_CNT_W         = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Width of a channel index; never narrower than one bit.
    function automatic int src_w(input int num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A level must hold the value FIFO_DEPTH itself, hence one extra bit.
    function automatic int lvl_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    typedef logic [lvl_w(DEFAULT_FIFO_DEPTH)-1:0] level_t;

endpackage

// File: rtl/param_demux_router_if.sv
// Handshake bundle between the packet source, the router and the per-channel consumers.
interface param_demux_router_if
    import demux_router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int SRC_W = src_w(NUM_OUT);
    localparam int LVL_W = lvl_w(FIFO_DEPTH);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [SRC_W-1:0]          in_src;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT*LVL_W-1:0]  out_level;

    modport master (
        output in_valid, in_data, in_src, out_ready,
        input  in_ready, out_valid, out_data, out_level
    );

    modport slave (
        input  in_valid, in_data, in_src, out_ready,
        output in_ready, out_valid, out_data, out_level
    );
endinterface

// File: rtl/demux_router_fifo.sv
// Per-channel synchronous FIFO; head is visible combinationally and reads as 0 when empty.
module demux_router_fifo
    import demux_router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    output logic                           full,
    input  logic                           pop,
    output logic [DATA_W-1:0]              head_data,
    output logic                           empty,
    output logic [lvl_w(FIFO_DEPTH)-1:0]   level
);
    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int LVL_W = lvl_w(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because head is masked by empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/param_demux_router.sv
// Routes one input stream to NUM_OUT buffered channels selected per beat by in_src.
// Optional DEMUX_ROUTER_DROP_EN: never backpressure; discard beats that cannot be stored and count them.
module param_demux_router
    import demux_router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    param_demux_router_if.slave   bus
`ifdef DEMUX_ROUTER_DROP_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    localparam int SRC_W = src_w(NUM_OUT);
    localparam int LVL_W = lvl_w(FIFO_DEPTH);
    localparam logic [SRC_W:0] NUM_OUT_L = (SRC_W+1)'(NUM_OUT);

    logic [NUM_OUT-1:0]       full_w, empty_w, push_w, pop_w, valid_w;
    logic [(1<<SRC_W)-1:0]    full_pad;
    logic [SRC_W:0]           src_ext;
    logic                     src_ok, sel_full, accept_w;

    // Out-of-range indices look like permanently full channels.
    always_comb begin
        full_pad                = '1;
        full_pad[NUM_OUT-1:0]   = full_w;
    end

    assign src_ext  = {1'b0, bus.in_src};
    assign src_ok   = (src_ext < NUM_OUT_L);
    assign sel_full = full_pad[bus.in_src];
    assign accept_w = bus.in_valid && !reset && src_ok && !sel_full;

`ifdef DEMUX_ROUTER_DROP_EN
    logic                  drop_w;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign bus.in_ready = !reset;
    assign drop_w       = bus.in_valid && !reset && !(src_ok && !sel_full);
    assign drop_cnt     = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_w && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end
`else
    // Ready ignores a same-cycle pop on a full channel to keep this path short.
    assign bus.in_ready = !reset && src_ok && !sel_full;
`endif

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
            logic [DATA_W-1:0] head_w;
            logic [LVL_W-1:0]  level_w;

            assign push_w[gi]  = accept_w && (src_ext == (SRC_W+1)'(gi));
            assign valid_w[gi] = !reset && !empty_w[gi];
            assign pop_w[gi]   = valid_w[gi] && bus.out_ready[gi];

            demux_router_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push_w[gi]),
                .push_data (bus.in_data),
                .full      (full_w[gi]),
                .pop       (pop_w[gi]),
                .head_data (head_w),
                .empty     (empty_w[gi]),
                .level     (level_w)
            );

            assign bus.out_data[gi*DATA_W +: DATA_W] = reset ? '0 : head_w;
            assign bus.out_level[gi*LVL_W +: LVL_W]  = reset ? '0 : level_w;
        end
    endgenerate

    assign bus.out_valid = valid_w;

endmodule

// File: tb/tb_param_demux_router.sv
// Directed and randomised checks of param_demux_router against per-channel queue model.
module tb_param_demux_router;
    localparam int DATA_W = 8;
    localparam int NOUT   = 4;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_demux_router_if #(.DATA_W(DATA_W), .NUM_OUT(NOUT), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef DEMUX_ROUTER_DROP_EN
    logic [15:0] drop_cnt;
    param_demux_router #(.DATA_W(DATA_W), .NUM_OUT(NOUT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .drop_cnt(drop_cnt));
`else
    param_demux_router #(.DATA_W(DATA_W), .NUM_OUT(NOUT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
`endif

    int total = 0;
    int bad   = 0;
    int accepted  = 0;
    int dut_pops  = 0;
    logic [DATA_W-1:0] mq [NOUT][$];
    int exp_drop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: at each falling edge compare outputs with queues, then apply the next rising edge.
    always @(negedge clk) begin
        logic exp_rdy;
        logic was_full;
        int   s;
        s = int'(bus.in_src);
        if (reset) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_level", 32'(bus.out_level), 32'd0);
            chk("rst_out_data", bus.out_data, 32'd0);
            for (int k = 0; k < NOUT; k++) mq[k].delete();
            exp_drop = 0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                chk($sformatf("valid%0d", k), 32'(bus.out_valid[k]), 32'(mq[k].size() > 0));
                chk($sformatf("data%0d", k), 32'(bus.out_data[k*DATA_W +: DATA_W]),
                    (mq[k].size() > 0) ? 32'(mq[k][0]) : 32'd0);
                chk($sformatf("level%0d", k), 32'(bus.out_level[k*LVL_W +: LVL_W]), 32'(mq[k].size()));
            end
            was_full = (s >= NOUT) || (mq[s].size() >= DEPTH);
`ifdef DEMUX_ROUTER_DROP_EN
            exp_rdy = 1'b1;
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (bus.in_valid && was_full && exp_drop < 16'hFFFF) exp_drop++;
`else
            exp_rdy = !was_full;
`endif
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            for (int k = 0; k < NOUT; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) dut_pops++;
                if (mq[k].size() > 0 && bus.out_ready[k]) void'(mq[k].pop_front());
            end
            if (bus.in_valid && !was_full) begin
                mq[s].push_back(bus.in_data);
                accepted++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_src    = 2'd2;
        bus.in_data   = 8'h55;
        bus.out_ready = 4'b0000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lit_rst_ready", 32'(bus.in_ready), 32'd0);
            chk("lit_rst_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("lit_post_rst_level", 32'(bus.out_level), 32'd0);
        $display("txn reset: released, levels=%0h", bus.out_level);

        // Basic route
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1; bus.in_src = 2'd0; bus.in_data = 8'hA5;
        chk("lit_basic_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_src = 2'd3; bus.in_data = 8'h3C;
        chk("lit_o0_valid", 32'(bus.out_valid[0]), 32'd1);
        chk("lit_o0_data", 32'(bus.out_data[7:0]), 32'hA5);
        step();
        bus.in_valid = 1'b0;
        chk("lit_o3_data", 32'(bus.out_data[31:24]), 32'h3C);
        chk("lit_o0_gone", 32'(bus.out_valid[0]), 32'd0);
        step();
        chk("lit_basic_levels", 32'(bus.out_level), 32'd0);
        $display("txn basic: routed A5->0, 3C->3");

        // Fill channel 1 while stalled
        bus.out_ready = 4'b1101;
        bus.in_src = 2'd1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + i);
            chk("lit_fill_ready", 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
            $display("txn fill: beat %0h ready=%0b", bus.in_data, bus.in_ready);
            if (i < 4) step();
        end
        chk("lit_fill_level", 32'(bus.out_level[5:3]), 32'd4);
        bus.out_ready[1] = 1'b1;
        chk("lit_full_ready_with_pop", 32'(bus.in_ready), 32'd0);
        chk("lit_head10", 32'(bus.out_data[15:8]), 32'h10);
        step();
        chk("lit_ready_after_pop", 32'(bus.in_ready), 32'd1);
        chk("lit_head11", 32'(bus.out_data[15:8]), 32'h11);
        step();
        bus.in_valid = 1'b0;
        chk("lit_head12", 32'(bus.out_data[15:8]), 32'h12);
        step();
        chk("lit_head13", 32'(bus.out_data[15:8]), 32'h13);
        step();
        chk("lit_head14", 32'(bus.out_data[15:8]), 32'h14);
        step();
        chk("lit_ch1_empty", 32'(bus.out_level[5:3]), 32'd0);

        // Full channel 2 with concurrent pop
        bus.out_ready = 4'b1011;
        bus.in_src = 2'd2; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'(8'h20 + i);
            step();
        end
        bus.in_data = 8'h24;
        bus.out_ready[2] = 1'b1;
        chk("lit_full2_ready", 32'(bus.in_ready), 32'd0);
        chk("lit_full2_level", 32'(bus.out_level[8:6]), 32'd4);
        step();
        chk("lit_pop2_level", 32'(bus.out_level[8:6]), 32'd3);
        chk("lit_pop2_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("lit_pushpop2_level", 32'(bus.out_level[8:6]), 32'd3);
        $display("txn full_pop: ch2 level held at 3");
        for (int i = 0; i < 5; i++) step();

`ifdef DEMUX_ROUTER_DROP_EN
        bus.out_ready = 4'b1110;
        bus.in_src = 2'd0; bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = 8'(8'h40 + i);
            chk("lit_drop_ready", 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("lit_drop_cnt3", 32'(drop_cnt), 32'd3);
        chk("lit_drop_head", 32'(bus.out_data[7:0]), 32'h40);
        chk("lit_drop_level", 32'(bus.out_level[2:0]), 32'd4);
        @(negedge clk);
        #1;
        force dut.drop_cnt_q = 16'hFFFE;
        exp_drop = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        bus.in_valid = 1'b1;
        step(); step();
        bus.in_valid = 1'b0;
        step();
        chk("lit_drop_sat", 32'(drop_cnt), 32'hFFFF);
        $display("txn drop: drop_cnt=%0h", drop_cnt);
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) step();
`endif

        // Interleaved random traffic
        begin
            int start_acc;
            int cyc;
            start_acc = accepted;
            cyc = 0;
            while ((accepted - start_acc) < 200 && cyc < 3000) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_src    = 2'($urandom_range(0, NOUT - 1));
                bus.in_data   = 8'($urandom);
                bus.out_ready = 4'($urandom);
                step();
                cyc++;
            end
            chk("rand_budget", 32'((accepted - start_acc) >= 200), 32'd1);
            bus.in_valid  = 1'b0;
            bus.out_ready = 4'b1111;
            for (int i = 0; i < 8; i++) step();
            chk("rand_drained", 32'(bus.out_level), 32'd0);
            chk("no_loss_dup", 32'(dut_pops), 32'(accepted));
            $display("txn random: accepted=%0d popped=%0d cycles=%0d", accepted, dut_pops, cyc);
        end

        // Mid-operation reset discards queued beats
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_src = 2'd3; bus.in_data = 8'h77;
        step(); step();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("lit_midrst_level", 32'(bus.out_level), 32'd0);
        $display("txn midreset: levels=%0h", bus.out_level);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
